// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the sync_fifo read-side stream controller.
`ifndef FIFO_WIDTH
`define FIFO_WIDTH 8
`endif

package fifo_stream_reader_pkg;

  localparam int FIFO_WIDTH_DEF = `FIFO_WIDTH;
  localparam int WORD_COUNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream; master is the reader side.
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF
);

  logic             fifo_read;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output fifo_read, m_valid, m_data,
    input  fifo_data, fifo_empty, m_ready
  );

  modport slave (
    input  fifo_read, m_valid, m_data,
    output fifo_data, fifo_empty, m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_buf.sv
// DEPTH x WIDTH circular word store; pointers reset, data array deliberately unreset.
module fifo_stream_reader_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Issues sync_fifo reads and buffers returned words onto a valid/ready stream (2-cycle latency).
// Optional handshake counter on word_count is enabled by defining FIFO_RD_COUNT_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  fifo_stream_reader_if.master    bus,
  output logic                    busy
`ifdef FIFO_RD_COUNT_EN
  ,
  output logic [WORD_COUNT_W-1:0] word_count
`endif
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  rd_state_t        state, state_nxt;
  logic             pend;
  logic [AW:0]      buf_cnt, buf_cnt_nxt;
  logic [AW:0]      occ, occ_nxt;
  logic             capture, pop;
  logic [WIDTH-1:0] head;

  // Occupancy counts the in-flight read so the buffer can never be overcommitted.
  assign occ           = buf_cnt + {{AW{1'b0}}, pend};
  assign bus.fifo_read = en & ~bus.fifo_empty & (occ < CNT_FULL);
  assign capture       = pend;
  assign bus.m_valid   = (buf_cnt != '0);
  assign pop           = bus.m_valid & bus.m_ready;
  assign bus.m_data    = bus.m_valid ? head : '0;
  assign busy          = (state != IDLE);

  fifo_stream_reader_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (capture),
    .wr_data (bus.fifo_data),
    .rd_en   (pop),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pend    <= 1'b0;
      buf_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pend    <= bus.fifo_read;
      buf_cnt <= buf_cnt_nxt;
    end
  end

  always_comb begin
    buf_cnt_nxt = buf_cnt;
    state_nxt   = FETCH;
    case ({capture, pop})
      2'b10:   buf_cnt_nxt = buf_cnt + CNT_ONE;
      2'b01:   buf_cnt_nxt = buf_cnt - CNT_ONE;
      default: buf_cnt_nxt = buf_cnt;
    endcase
    occ_nxt = buf_cnt_nxt + {{AW{1'b0}}, bus.fifo_read};
    if (occ_nxt == '0)
      state_nxt = IDLE;
    else if (occ_nxt == CNT_FULL)
      state_nxt = FULL;
  end

`ifdef FIFO_RD_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      word_count <= '0;
    else if (pop)
      word_count <= word_count + WORD_COUNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: DEPTH=4 and DEPTH=2 readers, each fed by a behavioural sync_fifo model.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  logic clk;
  logic rst;
  logic en;
  logic en2;
  logic busy;
  logic busy2;
`ifdef FIFO_RD_COUNT_EN
  logic [15:0] wc;
  logic [15:0] wc2;
`endif

  int total;
  int bad;

  fifo_stream_reader_if #(.WIDTH(8)) bus4 ();
  fifo_stream_reader_if #(.WIDTH(8)) bus2 ();

  fifo_stream_reader #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (rst),
    .en    (en),
    .bus   (bus4),
    .busy  (busy)
`ifdef FIFO_RD_COUNT_EN
    ,
    .word_count (wc)
`endif
  );

  fifo_stream_reader #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk   (clk),
    .reset (rst),
    .en    (en2),
    .bus   (bus2),
    .busy  (busy2)
`ifdef FIFO_RD_COUNT_EN
    ,
    .word_count (wc2)
`endif
  );

  // sync_fifo models: registered data_out one cycle after read, empty from occupancy.
  logic [7:0] fmem  [256];
  logic [7:0] fmem2 [256];
  logic [7:0] fwr, frd, fwr2, frd2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frd            <= fwr;
      bus4.fifo_data <= 8'h00;
    end else if (bus4.fifo_read && (fwr != frd)) begin
      bus4.fifo_data <= fmem[frd];
      frd            <= frd + 8'd1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      frd2           <= fwr2;
      bus2.fifo_data <= 8'h00;
    end else if (bus2.fifo_read && (fwr2 != frd2)) begin
      bus2.fifo_data <= fmem2[frd2];
      frd2           <= frd2 + 8'd1;
    end
  end

  assign bus4.fifo_empty = (fwr == frd);
  assign bus2.fifo_empty = (fwr2 == frd2);

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fmem[fwr] = v;
    fwr = fwr + 8'd1;
  endtask

  task automatic push2(input logic [7:0] v);
    fmem2[fwr2] = v;
    fwr2 = fwr2 + 8'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] t1w [5];
    int n;
    int reads;
    int got;
    int gaps;
    int cyc;
    int hs;
    logic [7:0] diff;

    t1w[0] = 8'd3; t1w[1] = 8'd7; t1w[2] = 8'd11; t1w[3] = 8'd19; t1w[4] = 8'd30;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    fwr   = 8'd0;
    fwr2  = 8'd0;
    en    = 1'b0;
    en2   = 1'b0;
    bus4.m_ready = 1'b0;
    bus2.m_ready = 1'b0;
    rst   = 1'b1;
    tick();
    tick();

    // Reset values
    chk("rst_fifo_read", bus4.fifo_read, 1'b0);
    chk("rst_m_valid",   bus4.m_valid,   1'b0);
    chk("rst_m_data",    bus4.m_data,    8'h00);
    chk("rst_busy",      busy,           1'b0);
`ifdef FIFO_RD_COUNT_EN
    chk("rst_word_count", wc, 16'h0000);
`endif
    rst = 1'b0;
    tick();

    // Five words streamed with the consumer always ready
    en = 1'b1;
    bus4.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(t1w[i]);
    #1;
    chk("t1_first_read", bus4.fifo_read, 1'b1);
    n = 0;
    while (!bus4.m_valid && n < 10) begin
      tick();
      n++;
    end
    chk("t1_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t1_word", {bus4.m_valid, bus4.m_data}, {1'b1, t1w[i]});
      tick();
    end
    chk("t1_busy_after_last", busy, 1'b0);
    chk("t1_valid_after_last", bus4.m_valid, 1'b0);
`ifdef FIFO_RD_COUNT_EN
    chk("t1_word_count", wc, 16'd5);
`endif

    // Backpressure: 16 words, consumer stalled
    do_reset();
    en = 1'b1;
    bus4.m_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    #1;
    reads = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus4.fifo_read) reads++;
      tick();
    end
    chk("t2_read_pulses", reads, 4);
    chk("t2_state_full", 32'(dut.state), 32'(FULL));
    chk("t2_no_read_full", bus4.fifo_read, 1'b0);
    chk("t2_head_held", {bus4.m_valid, bus4.m_data}, {1'b1, 8'h40});
    bus4.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_word", {bus4.m_valid, bus4.m_data}, {1'b1, 8'h40 + 8'(i)});
      tick();
    end

    // DEPTH=2 throughput limit
    do_reset();
    en2 = 1'b1;
    bus2.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push2(8'h80 + 8'(i));
    #1;
    cyc  = 0;
    got  = 0;
    gaps = 0;
    while (got < 8 && cyc < 40) begin
      if (bus2.m_valid) begin
        chk("t3_word", bus2.m_data, 8'h80 + 8'(got));
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      tick();
      cyc++;
    end
    chk("t3_count", got, 8);
    chk("t3_cycles_le_17", (cyc >= 10) && (cyc <= 17), 1'b1);
    chk("t3_has_gaps", gaps > 0, 1'b1);
    en2 = 1'b0;

    // en dropped right after a read is issued
    do_reset();
    en = 1'b0;
    bus4.m_ready = 1'b1;
    push(8'hA0); push(8'hA1); push(8'hA2);
    #1;
    chk("t4_no_read_en0", bus4.fifo_read, 1'b0);
    en = 1'b1;
    #1;
    chk("t4_read_en1", bus4.fifo_read, 1'b1);
    tick();
    en = 1'b0;
    #1;
    reads = 0;
    got   = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.fifo_read) reads++;
      if (bus4.m_valid) begin
        chk("t4_pending_word", bus4.m_data, 8'hA0);
        got++;
      end
      tick();
    end
    chk("t4_reads_while_off", reads, 0);
    chk("t4_words_while_off", got, 1);
    en  = 1'b1;
    cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (bus4.m_valid) begin
        chk("t4_resume_word", bus4.m_data, 8'hA0 + 8'(got));
        got++;
      end
      tick();
      cyc++;
    end
    chk("t4_resume_count", got, 3);

    // Reset mid-stream with three words buffered and a read about to issue
    do_reset();
    en = 1'b1;
    bus4.m_ready = 1'b0;
    push(8'hC0); push(8'hC1); push(8'hC2);
    repeat (6) tick();
    chk("t5_buffered_head", {bus4.m_valid, busy, bus4.m_data}, {1'b1, 1'b1, 8'hC0});
    push(8'hD0); push(8'hD1);
    #1;
    chk("t5_read_before_reset", bus4.fifo_read, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", bus4.m_valid,   1'b0);
    chk("t5_rst_busy",  busy,           1'b0);
    chk("t5_rst_read",  bus4.fifo_read, 1'b0);
    tick();
    rst = 1'b0;
    bus4.m_ready = 1'b1;
    got   = 0;
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus4.m_valid) got++;
      if (bus4.fifo_read) reads++;
      tick();
    end
    chk("t5_nothing_delivered", got, 0);
    chk("t5_fifo_empty", bus4.fifo_empty, 1'b1);
    chk("t5_no_reads", reads, 0);

`ifdef FIFO_RD_COUNT_EN
    // Handshake counter wrap
    do_reset();
    en = 1'b1;
    bus4.m_ready = 1'b1;
    hs  = 0;
    cyc = 0;
    while (hs < 65535 && cyc < 70000) begin
      diff = fwr - frd;
      if (diff < 8'd8) push(8'(hs));
      if (bus4.m_valid && bus4.m_ready) hs++;
      tick();
      cyc++;
    end
    bus4.m_ready = 1'b0;
    #1;
    chk("t6_count_ffff", wc, 16'hFFFF);
    chk("t6_valid_ready", bus4.m_valid, 1'b1);
    bus4.m_ready = 1'b1;
    tick();
    chk("t6_count_wrap", wc, 16'h0000);
    bus4.m_ready = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
